// File: rtl/register_file_scoreboarded.sv
// Scoreboarded integer register file: generic read/write ports, per-register busy bits,
// and a one-register-per-cycle post-reset clear sweep. Optional macro: REGISTER_FILE_BYPASS_EN.
module register_file_scoreboarded #(
    parameter int DataWidth      = 32,
    parameter int RegisterCount  = 32,
    parameter int ReadPortCount  = 2,
    parameter int WritePortCount = 2,
    parameter int AddressWidth   = $clog2(RegisterCount)
) (
    input  logic                                         clk_i,
    input  logic                                         rst_i,
    output logic                                         init_done_o,
    input  logic [ReadPortCount-1:0][AddressWidth-1:0]   read_address_i,
    output logic [ReadPortCount-1:0][DataWidth-1:0]      read_data_o,
    output logic [ReadPortCount-1:0]                     read_busy_o,
    input  logic [WritePortCount-1:0]                    write_enable_i,
    input  logic [WritePortCount-1:0][AddressWidth-1:0]  write_address_i,
    input  logic [WritePortCount-1:0][DataWidth-1:0]     write_data_i,
    input  logic                                         reserve_enable_i,
    input  logic [AddressWidth-1:0]                      reserve_address_i,
    input  logic                                         flush_i
);

    typedef enum logic {INIT, READY} state_t;

    state_t                    state_q, state_d;
    logic [AddressWidth-1:0]   counter_q, counter_d;
    logic [RegisterCount-1:0]  busy_q, busy_d;
    logic                      init_done_q;
    logic [DataWidth-1:0]      regs [RegisterCount];
    logic [WritePortCount-1:0] write_valid;

    assign init_done_o = init_done_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= INIT;
            counter_q   <= '0;
            busy_q      <= '0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            busy_q      <= busy_d;
            init_done_q <= (state_q == READY);
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        if (state_q == INIT) begin
            counter_d = counter_q + 1'b1;
            if (counter_q == AddressWidth'(RegisterCount - 1)) begin
                state_d = READY;
            end
        end
    end

    always_comb begin
        write_valid = '0;
        for (int w = 0; w < WritePortCount; w++) begin
            write_valid[w] = !rst_i && (state_q == READY) && write_enable_i[w]
                             && (write_address_i[w] != '0);
        end
    end

    // Ordering matters: writes clear, a reservation then re-sets, a flush overrides both.
    always_comb begin
        busy_d = busy_q;
        if (state_q == READY) begin
            for (int w = 0; w < WritePortCount; w++) begin
                if (write_valid[w]) begin
                    busy_d[write_address_i[w]] = 1'b0;
                end
            end
            if (reserve_enable_i && (reserve_address_i != '0)) begin
                busy_d[reserve_address_i] = 1'b1;
            end
            if (flush_i) begin
                busy_d = '0;
            end
        end
        busy_d[0] = 1'b0;
    end

    // Storage has no reset so it can map onto RAM; the sweep clears it instead.
    always_ff @(posedge clk_i) begin
        if (!rst_i && (state_q == INIT)) begin
            regs[counter_q] <= '0;
        end else begin
            for (int w = 0; w < WritePortCount; w++) begin
                if (write_valid[w]) begin
                    regs[write_address_i[w]] <= write_data_i[w];
                end
            end
        end
    end

    always_comb begin
        read_data_o = '0;
        read_busy_o = '0;
        for (int r = 0; r < ReadPortCount; r++) begin
            if ((state_q == READY) && (read_address_i[r] != '0)) begin
                read_data_o[r] = regs[read_address_i[r]];
                read_busy_o[r] = busy_q[read_address_i[r]];
`ifdef REGISTER_FILE_BYPASS_EN
                for (int w = 0; w < WritePortCount; w++) begin
                    if (write_valid[w] && (write_address_i[w] == read_address_i[r])) begin
                        read_data_o[r] = write_data_i[w];
                        read_busy_o[r] = 1'b0;
                    end
                end
`endif
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (!rst_i && (state_q == READY)) begin
            assert ((regs[0] == '0) && !busy_q[0])
            else $fatal(1, "register 0 modified or marked busy");
        end
    end
`endif

endmodule
